// File: rtl/ysyx_23060025_csr_trap_unit_pkg.sv
// Shared CSR addresses, operation encodings, trap causes and mstatus layout
// for the machine-mode CSR/trap unit.
package ysyx_23060025_csr_trap_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MCAUSE_MTI   = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_ECALL = 32'h0000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIP_MTIP     = 7;

    localparam logic [31:0] MSTATUS_MPP_M  = 32'h0000_1800;
    localparam logic [31:0] MVENDORID_VAL  = 32'h7973_7978;
    localparam logic [31:0] MARCHID_VAL    = 32'd23060025;
    localparam logic [31:0] MTVEC_MTI_OFFS = 32'h0000_001C;

    // Read-only space plus mip, which is a live view of the interrupt line.
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return (addr[11:10] == 2'b11) || (addr == CSR_MIP);
    endfunction

endpackage

// File: rtl/ysyx_23060025_csr_counter64.sv
// 64-bit counter with independently writable halves; a write to either half
// suppresses that cycle's increment and never carries between halves.
module ysyx_23060025_csr_counter64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_d[31:0]  = wdata;
            if (wr_hi) cnt_d[63:32] = wdata;
        end else if (inc) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign lo = cnt_q[31:0];
    assign hi = cnt_q[63:32];

endmodule

// File: rtl/ysyx_23060025_csr_trap_unit.sv
// Machine-mode CSR file with timer-interrupt/ecall trap entry, mret and
// mcycle/minstret counters; sits beside the execute stage.
module ysyx_23060025_csr_trap_unit
    import ysyx_23060025_csr_trap_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter bit HAS_COUNTERS = 1'b1,
    parameter bit VECTORED_EN  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [11:0]           csr_addr_i,
    input  logic [1:0]            csr_op_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  ecall_i,
    input  logic                  mret_i,
    input  logic                  retire_i,
    input  logic                  irq_timer_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  illegal_o,
    output logic                  trap_o,
    output logic [DATA_WIDTH-1:0] trap_pc_o,
    output logic [DATA_WIDTH-1:0] mret_pc_o
);

    localparam logic [31:0] MTVEC_WMASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

    logic        mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;

    csr_op_e     op;
    logic        csr_known, write_intent, int_take, ecall_take, mret_take, csr_we;
    logic [31:0] csr_old, csr_new, trap_base;

    assign op = csr_op_e'(csr_op_i);

    always_comb begin
        csr_known = 1'b1;
        csr_old   = '0;
        case (csr_addr_i)
            CSR_MSTATUS:   csr_old = MSTATUS_MPP_M | (32'(mpie_q) << MSTATUS_MPIE)
                                                   | (32'(mie_q) << MSTATUS_MIE);
            CSR_MIE:       csr_old = 32'(mtie_q) << MIE_MTIE;
            CSR_MTVEC:     csr_old = mtvec_q;
            CSR_MSCRATCH:  csr_old = mscratch_q;
            CSR_MEPC:      csr_old = mepc_q;
            CSR_MCAUSE:    csr_old = mcause_q;
            CSR_MIP:       csr_old = 32'(irq_timer_i) << MIP_MTIP;
            CSR_MCYCLE:    csr_old = HAS_COUNTERS ? cyc_lo : '0;
            CSR_MCYCLEH:   csr_old = HAS_COUNTERS ? cyc_hi : '0;
            CSR_MINSTRET:  csr_old = HAS_COUNTERS ? ins_lo : '0;
            CSR_MINSTRETH: csr_old = HAS_COUNTERS ? ins_hi : '0;
            CSR_MVENDORID: csr_old = MVENDORID_VAL;
            CSR_MARCHID:   csr_old = MARCHID_VAL;
            default:       csr_known = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read: legal on read-only CSRs and no write.
    assign write_intent = (op == CSR_OP_RW) || (wdata_i != '0);
    assign illegal_o    = !reset && (op != CSR_OP_NONE)
                          && (!csr_known || (csr_is_ro(csr_addr_i) && write_intent));
    assign rdata_o      = illegal_o ? '0 : csr_old;

    always_comb begin
        case (op)
            CSR_OP_RW: csr_new = wdata_i;
            CSR_OP_RS: csr_new = csr_old | wdata_i;
            CSR_OP_RC: csr_new = csr_old & ~wdata_i;
            default:   csr_new = csr_old;
        endcase
    end

    assign int_take   = !reset && retire_i && mie_q && mtie_q && irq_timer_i;
    assign ecall_take = !reset && !int_take && ecall_i && retire_i;
    assign trap_o     = int_take || ecall_take;
    assign mret_take  = !reset && !trap_o && mret_i && retire_i;
    assign csr_we     = !reset && !trap_o && !mret_take && retire_i
                        && (op != CSR_OP_NONE) && !illegal_o && write_intent;

    assign trap_base = {mtvec_q[31:2], 2'b00};
    assign trap_pc_o = (int_take && mtvec_q[0]) ? trap_base + MTVEC_MTI_OFFS : trap_base;
    assign mret_pc_o = mepc_q;

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap_o) begin
            mepc_d   = pc_i & 32'hFFFF_FFFC;
            mcause_d = int_take ? MCAUSE_MTI : MCAUSE_ECALL;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_take) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_d  = csr_new[MSTATUS_MIE];
                    mpie_d = csr_new[MSTATUS_MPIE];
                end
                CSR_MIE:      mtie_d     = csr_new[MIE_MTIE];
                CSR_MTVEC:    mtvec_d    = csr_new & MTVEC_WMASK;
                CSR_MSCRATCH: mscratch_d = csr_new;
                CSR_MEPC:     mepc_d     = csr_new & 32'hFFFF_FFFC;
                CSR_MCAUSE:   mcause_d   = csr_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtie_q     <= mtie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    ysyx_23060025_csr_counter64 u_mcycle (
        .clock (clock),
        .reset (reset),
        .inc   (HAS_COUNTERS),
        .wr_lo (HAS_COUNTERS && csr_we && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi (HAS_COUNTERS && csr_we && (csr_addr_i == CSR_MCYCLEH)),
        .wdata (csr_new),
        .lo    (cyc_lo),
        .hi    (cyc_hi)
    );

    ysyx_23060025_csr_counter64 u_minstret (
        .clock (clock),
        .reset (reset),
        .inc   (HAS_COUNTERS && retire_i && !trap_o),
        .wr_lo (HAS_COUNTERS && csr_we && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi (HAS_COUNTERS && csr_we && (csr_addr_i == CSR_MINSTRETH)),
        .wdata (csr_new),
        .lo    (ins_lo),
        .hi    (ins_hi)
    );

endmodule

// File: tb/tb_ysyx_23060025_csr_trap_unit.sv
// Scoreboard bench: the driver pushes expected outputs from an architectural
// model each cycle; a negedge monitor pops and compares against the DUT.
module tb_ysyx_23060025_csr_trap_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] csr_addr_i = '0;
    logic [1:0]  csr_op_i = '0;
    logic [31:0] wdata_i = '0, pc_i = '0;
    logic        ecall_i = 1'b0, mret_i = 1'b0, retire_i = 1'b0, irq_timer_i = 1'b0;
    logic [31:0] rdata_o, trap_pc_o, mret_pc_o;
    logic        illegal_o, trap_o;

    ysyx_23060025_csr_trap_unit dut (
        .clock(clock), .reset(reset), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
        .wdata_i(wdata_i), .ecall_i(ecall_i), .mret_i(mret_i), .retire_i(retire_i),
        .irq_timer_i(irq_timer_i), .pc_i(pc_i), .rdata_o(rdata_o), .illegal_o(illegal_o),
        .trap_o(trap_o), .trap_pc_o(trap_pc_o), .mret_pc_o(mret_pc_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit        rst;
        bit [31:0] rdata, tpc, mpc;
        bit        ill, trap;
    } exp_t;

    exp_t      sb[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    bit [31:0] m_csr[int];
    bit [63:0] m_cyc, m_ins;

    task automatic model_reset();
        m_csr.delete();
        m_csr['h300] = 32'h0000_1800;
        m_csr['h304] = 0;
        m_csr['h305] = 0;
        m_csr['h340] = 0;
        m_csr['h341] = 0;
        m_csr['h342] = 0;
        m_csr['hF11] = 32'h7973_7978;
        m_csr['hF12] = 32'd23060025;
        m_cyc = 0;
        m_ins = 0;
    endtask

    function automatic bit m_known(input bit [11:0] a);
        return m_csr.exists(int'(a)) || (a inside {12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82});
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a, input bit irq);
        if (m_csr.exists(int'(a))) return m_csr[int'(a)];
        case (a)
            12'h344: return irq ? 32'h80 : 32'h0;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input bit [11:0] a, input bit [31:0] v);
        case (a)
            12'h300: m_csr['h300] = 32'h1800 | (v & 32'h88);
            12'h304: m_csr['h304] = v & 32'h80;
            12'h305: m_csr['h305] = v & ~32'h2;
            12'h341: m_csr['h341] = v & ~32'h3;
            default: m_csr[int'(a)] = v;
        endcase
    endtask

    // One cycle: apply inputs, push what the DUT must show, advance the model.
    task automatic drive(input bit rst, input bit [11:0] a, input bit [1:0] op,
                         input bit [31:0] wd, input bit ec, input bit mr, input bit rt,
                         input bit irq, input bit [31:0] pc);
        exp_t      e;
        bit [31:0] old, ms, nv;
        bit        ro, wi, ill, t_int, t_ec;
        bit [63:0] n_cyc, n_ins;
        reset = rst; csr_addr_i = a; csr_op_i = op; wdata_i = wd;
        ecall_i = ec; mret_i = mr; retire_i = rt; irq_timer_i = irq; pc_i = pc;
        e = '{default: 0};
        e.rst = rst;
        if (rst) begin
            sb.push_back(e);
            model_reset();
        end else begin
            old   = m_read(a, irq);
            ro    = (a[11:10] == 2'b11) || (a == 12'h344);
            wi    = (op == 2'd1) || (wd != 0);
            ill   = (op != 0) && (!m_known(a) || (ro && wi));
            ms    = m_csr['h300];
            t_int = rt && ms[3] && m_csr['h304][7] && irq;
            t_ec  = !t_int && ec && rt;
            e.ill   = ill;
            e.rdata = ill ? 32'h0 : old;
            e.trap  = t_int || t_ec;
            e.tpc   = (m_csr['h305] & ~32'h3) + ((t_int && m_csr['h305][0]) ? 32'd28 : 32'd0);
            e.mpc   = m_csr['h341];
            sb.push_back(e);
            n_cyc = m_cyc + 1;
            n_ins = m_ins + 64'((rt && !e.trap) ? 1 : 0);
            if (e.trap) begin
                m_csr['h341] = pc & ~32'h3;
                m_csr['h342] = t_int ? 32'h8000_0007 : 32'h0000_000B;
                m_csr['h300] = 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
            end else if (mr && rt) begin
                m_csr['h300] = 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
            end else if (rt && op != 0 && !ill && wi) begin
                nv = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
                case (a)
                    12'hB00: n_cyc = {m_cyc[63:32], nv};
                    12'hB80: n_cyc = {nv, m_cyc[31:0]};
                    12'hB02: n_ins = {m_ins[63:32], nv};
                    12'hB82: n_ins = {nv, m_ins[31:0]};
                    default: m_write(a, nv);
                endcase
            end
            m_cyc = n_cyc;
            m_ins = n_ins;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input bit [11:0] a);
        drive(0, a, 2'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input bit [11:0] a, input bit [1:0] op, input bit [31:0] d);
        drive(0, a, op, d, 0, 0, 1, 0, 0);
    endtask

    task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("trap_o", 32'(trap_o), 32'(e.trap));
                chk("illegal_o", 32'(illegal_o), 32'(e.ill));
                if (!e.rst) begin
                    chk($sformatf("rdata_o@%03h", csr_addr_i), rdata_o, e.rdata);
                    chk("trap_pc_o", trap_pc_o, e.tpc);
                    chk("mret_pc_o", mret_pc_o, e.mpc);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    bit [11:0] addrs[16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                             12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12,
                             12'h7C0, 12'h123, 12'h300};

    initial begin : driver
        @(posedge clock);
        #1;
        // Reset must mask a would-be trap and an illegal access.
        drive(1, 12'hF11, 2'd1, 32'h1, 1, 0, 1, 1, 32'h100);
        drive(1, 12'h000, 2'd0, 0, 0, 0, 0, 0, 0);
        rd(12'hB00); rd(12'h300); rd(12'hF11); rd(12'hF12);
        repeat (6) rd(12'h340);
        rd(12'hB00); rd(12'hB80);
        // Vectored timer interrupt.
        wr(12'h305, 2'd1, 32'h8000_0101);
        wr(12'h300, 2'd2, 32'h8);
        wr(12'h304, 2'd2, 32'h80);
        drive(0, 12'h000, 2'd0, 0, 0, 0, 1, 1, 32'h8000_0040);
        rd(12'h341); rd(12'h342); rd(12'h300);
        // ecall then mret.
        wr(12'h305, 2'd1, 32'h8000_0100);
        wr(12'h300, 2'd2, 32'h8);
        rd(12'hB02);
        drive(0, 12'hB02, 2'd0, 0, 1, 0, 1, 0, 32'h8000_0010);
        rd(12'hB02); rd(12'h342); rd(12'h300);
        drive(0, 12'h300, 2'd0, 0, 0, 1, 1, 0, 32'h8000_0010);
        rd(12'h300);
        // ecall beats a same-cycle CSR write.
        drive(0, 12'h340, 2'd1, 32'hDEAD, 1, 0, 1, 0, 32'h8000_0020);
        rd(12'h340);
        // Illegal and read-only accesses.
        wr(12'hF11, 2'd1, 32'h1234);
        wr(12'h7C0, 2'd2, 32'h1);
        wr(12'hF11, 2'd2, 32'h0);
        rd(12'hF11);
        // Counter half writes and carry.
        wr(12'hB00, 2'd1, 32'hFFFF_FFFF);
        wr(12'hB80, 2'd1, 32'h0);
        rd(12'hB00); rd(12'hB80);
        wr(12'hB00, 2'd3, 32'hFFFF_FFFF);
        rd(12'hB00); rd(12'hB00);
        for (int i = 0; i < 600; i++) begin
            drive(0, addrs[$urandom_range(0, 15)], 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom(),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom());
        end
        rd(12'h300);
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
